dm_responder: RTL

- Memory-side responder for the CPU's data-memory port.
- Accepts one read or write request at a time from the MEM stage and holds it for a programmable number of cycles, modelling slow memory.
- Completes the access, returning read data or a write acknowledge.
- Drives rdy so the CPU's hazard unit can stall the pipeline while an access is outstanding.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/dm_responder_if.sv | 24 ++
 rtl/dm_array.sv | 36 +++
 rtl/dm_responder.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Types and widths shared between the CPU datapath and the data-memory responder.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/dm_responder_if.sv
// Data-memory port between the CPU MEM stage (master) and the memory responder (slave).
interface dm_responder_if;

    logic [cpu_pkg::ADDR_W-1:0] addr;
    logic                       re;
    logic                       we;
    logic [cpu_pkg::DATA_W-1:0] wrt_data;
    logic [cpu_pkg::DATA_W-1:0] rd_data;
    logic                       vld;
    logic                       wack;
    logic                       rdy;
    logic                       err;

    modport master (
        output addr, re, we, wrt_data,
        input  rd_data, vld, wack, rdy, err
    );

    modport slave (
        input  addr, re, we, wrt_data,
        output rd_data, vld, wack, rdy, err
    );

endinterface

// File: rtl/dm_array.sv
// Single-port word storage with synchronous write and registered read.
module dm_array
    import cpu_pkg::*;
#(
    parameter int DEPTH_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DEPTH_W-1:0] addr,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_W];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    // Only the output register is reset; the storage itself keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (rd_en) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dm_responder.sv
// Slow-memory responder: accepts one access, holds it LATENCY cycles, then completes it.
module dm_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH_W = 12,
    parameter int LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst,
    dm_responder_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    op_t                 op_reg, op_next;
    logic                err_reg, err_next;
    logic                vld_reg, vld_next;
    logic                wack_reg, wack_next;
    logic                zero_reg, zero_next;
    logic                wr_en, rd_en;
    logic                oor;
    logic [DATA_W-1:0]   arr_rdata;

    generate
        if (DEPTH_W < ADDR_W) begin : g_oor
            assign oor = |addr_reg[ADDR_W-1:DEPTH_W];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        op_next    = op_reg;
        err_next   = err_reg;
        zero_next  = zero_reg;
        vld_next   = 1'b0;
        wack_next  = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.re || bus.we) begin
                    addr_next  = bus.addr;
                    data_next  = bus.wrt_data;
                    op_next    = bus.we ? OP_WR : OP_RD;
                    cnt_next   = CNT_INIT;
                    state_next = BUSY;
                    if (bus.re && bus.we) begin
                        err_next = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next = IDLE;
                    if (op_reg == OP_WR) begin
                        wack_next = 1'b1;
                        wr_en     = ~oor;
                    end else begin
                        vld_next  = 1'b1;
                        rd_en     = 1'b1;
                        zero_next = oor;
                    end
                    if (oor) begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            data_reg  <= '0;
            op_reg    <= OP_RD;
            err_reg   <= 1'b0;
            vld_reg   <= 1'b0;
            wack_reg  <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            op_reg    <= op_next;
            err_reg   <= err_next;
            vld_reg   <= vld_next;
            wack_reg  <= wack_next;
            zero_reg  <= zero_next;
        end
    end

    // A reset arriving on the completion edge must abandon the access, so storage enables are gated.
    dm_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr_reg[DEPTH_W-1:0]),
        .wr_en (wr_en & ~rst),
        .rd_en (rd_en & ~rst),
        .wdata (data_reg),
        .rdata (arr_rdata)
    );

    assign bus.rd_data = zero_reg ? '0 : arr_rdata;
    assign bus.vld     = vld_reg;
    assign bus.wack    = wack_reg;
    assign bus.err     = err_reg;
    assign bus.rdy     = (state_reg == IDLE) && !rst;

endmodule
